ddr_wr_ctrl: RTL and testbench

DDR_WR_CTRL -- requirements
Module: ddr_wr_ctrl

---
 rtl/ddr_ctrl_pkg.sv | 18 +
 rtl/ddr_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_ddr_wr_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the DDR write/read controllers: one-hot controller
// states, MIG command encodings and the beat-counter type.
package ddr_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_REQ   = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_DONE  = 4'b1000
  } ctrl_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int CNT_WIDTH = 8;
  typedef logic [CNT_WIDTH-1:0] beat_cnt_t;

endpackage

// File: rtl/ddr_wr_ctrl.sv
// Burst write controller: arbitrates for the MIG, then streams BURST_LEN data
// beats from a FWFT FIFO and issues one write command per beat behind its data.
module ddr_wr_ctrl
  import ddr_ctrl_pkg::*;
#(
  parameter int          BURST_LEN  = 64,
  parameter int          ADDR_WIDTH = 28,
  parameter int          DATA_WIDTH = 128,
  parameter int unsigned ADDR_STEP  = 8,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_MAX   = 2 ** 27
) (
  input  logic                    ui_clk,
  input  logic                    rst,
  input  logic                    init_calib_complete,
  output logic                    wr_req,
  input  logic                    wr_ack,
  output logic                    wr_done,
  input  logic                    fifo_empty,
  input  logic [9:0]              fifo_rd_count,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy
);

  localparam beat_cnt_t             BURST_CNT  = beat_cnt_t'(BURST_LEN);
  localparam logic [9:0]            COUNT_MIN  = 10'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]   STEP_EXT   = (ADDR_WIDTH + 1)'(ADDR_STEP);
  localparam logic [ADDR_WIDTH:0]   MAX_EXT    = (ADDR_WIDTH + 1)'(ADDR_MAX);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(ADDR_BASE);

  ctrl_state_e             state;
  ctrl_state_e             state_next;
  beat_cnt_t               data_cnt;
  beat_cnt_t               cmd_cnt;
  logic                    burst_start;
  logic                    data_acc;
  logic                    cmd_acc;
  logic [ADDR_WIDTH:0]     addr_sum;
  logic [ADDR_WIDTH-1:0]   addr_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge ui_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    wr_req       = 1'b0;
    wr_done      = 1'b0;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    burst_start  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (init_calib_complete && (fifo_rd_count >= COUNT_MIN)) state_next = ST_REQ;
      end
      ST_REQ: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          state_next  = ST_WRITE;
          burst_start = 1'b1;
        end
      end
      ST_WRITE: begin
        app_wdf_wren = (data_cnt < BURST_CNT) && !fifo_empty;
        // A command may only follow data that has already been accepted.
        app_en       = (cmd_cnt < BURST_CNT) && (cmd_cnt < data_cnt);
        if ((data_cnt == BURST_CNT) && (cmd_cnt == BURST_CNT)) state_next = ST_DONE;
      end
      ST_DONE: begin
        wr_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset silences the handshakes in the same cycle it is asserted.
    if (rst) begin
      wr_req       = 1'b0;
      wr_done      = 1'b0;
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      burst_start  = 1'b0;
    end
  end

  assign data_acc   = app_wdf_wren & app_wdf_rdy;
  assign cmd_acc    = app_en & app_rdy;
  assign fifo_rd_en = data_acc;

  always_ff @(posedge ui_clk) begin
    if (rst || burst_start) begin
      data_cnt <= '0;
      cmd_cnt  <= '0;
    end else begin
      if (data_acc) data_cnt <= data_cnt + beat_cnt_t'(1);
      if (cmd_acc)  cmd_cnt  <= cmd_cnt + beat_cnt_t'(1);
    end
  end

  // One extra bit keeps the wrap compare exact when ADDR_MAX fills ADDR_WIDTH.
  assign addr_sum  = {1'b0, app_addr} + STEP_EXT;
  assign addr_next = (addr_sum >= MAX_EXT) ? BASE_ADDR : addr_sum[ADDR_WIDTH-1:0];

  always_ff @(posedge ui_clk) begin
    if (rst)          app_addr <= BASE_ADDR;
    else if (cmd_acc) app_addr <= addr_next;
  end

  assign app_cmd      = CMD_WR;
  assign app_wdf_data = fifo_dout;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

endmodule

// File: tb/tb_ddr_wr_ctrl.sv
// Directed bench for ddr_wr_ctrl with a burst-level reference model compared
// on every falling edge, plus literal per-burst expectations.
module tb_ddr_wr_ctrl;

  localparam int BL    = 4;
  localparam int AW    = 28;
  localparam int DW    = 32;
  localparam int STEP  = 8;
  localparam int BASE  = 0;
  localparam int AMAX  = 32;

  localparam int PH_IDLE = 0;
  localparam int PH_ASK  = 1;
  localparam int PH_XFER = 2;
  localparam int PH_FIN  = 3;

  logic          ui_clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_calib_complete = 1'b0;
  logic          wr_ack = 1'b0;
  logic          fifo_empty = 1'b0;
  logic [9:0]    fifo_rd_count = '0;
  logic [DW-1:0] fifo_dout = '0;
  logic          app_rdy = 1'b1;
  logic          app_wdf_rdy = 1'b1;

  logic          wr_req, wr_done, fifo_rd_en, app_en, app_wdf_wren, app_wdf_end;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic [DW-1:0] app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;

  ddr_wr_ctrl #(
    .BURST_LEN(BL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ADDR_STEP(STEP), .ADDR_BASE(BASE), .ADDR_MAX(AMAX)
  ) dut (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_done(wr_done),
    .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy)
  );

  always #5 ui_clk = ~ui_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level model and monitors, updated on the falling edge.
  int m_phase = PH_IDLE;
  int m_beats = 0;
  int m_cmds = 0;
  int m_total_cmds = 0;
  int mon_beats = 0;
  int mon_cmds = 0;
  int mon_dones = 0;
  logic pop_now = 1'b0;
  logic [AW-1:0] cmd_log[$];

  always @(negedge ui_clk) begin
    automatic logic e_req, e_done, e_wren, e_en, e_rd;
    automatic logic [AW-1:0] e_addr;
    automatic int data_ok, cmd_ok;
    e_req  = !rst && (m_phase == PH_ASK);
    e_done = !rst && (m_phase == PH_FIN);
    e_wren = !rst && (m_phase == PH_XFER) && (m_beats < BL) && !fifo_empty;
    e_en   = !rst && (m_phase == PH_XFER) && (m_cmds < BL) && (m_cmds < m_beats);
    e_rd   = e_wren && app_wdf_rdy;
    e_addr = AW'(BASE + (m_total_cmds * STEP) % (AMAX - BASE));

    check("wr_req", wr_req, e_req);
    check("wr_done", wr_done, e_done);
    check("app_wdf_wren", app_wdf_wren, e_wren);
    check("app_en", app_en, e_en);
    check("fifo_rd_en", fifo_rd_en, e_rd);
    check("app_addr", app_addr, e_addr);
    check("app_cmd", app_cmd, 3'b000);
    check("app_wdf_end", app_wdf_end, e_wren);
    check("app_wdf_mask", app_wdf_mask, '0);
    check("app_wdf_data", app_wdf_data, fifo_dout);

    pop_now = fifo_rd_en;
    if (app_wdf_wren && app_wdf_rdy) mon_beats++;
    if (app_en && app_rdy) begin
      mon_cmds++;
      cmd_log.push_back(app_addr);
    end
    if (wr_done) mon_dones++;

    data_ok = int'(e_rd);
    cmd_ok  = int'(e_en && app_rdy);
    if (rst) begin
      m_phase = PH_IDLE;
      m_beats = 0;
      m_cmds = 0;
      m_total_cmds = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (init_calib_complete && fifo_rd_count >= BL) m_phase = PH_ASK;
        PH_ASK: if (wr_ack) begin
          m_phase = PH_XFER;
          m_beats = 0;
          m_cmds = 0;
        end
        PH_XFER: begin
          if (m_beats == BL && m_cmds == BL) m_phase = PH_FIN;
          m_beats += data_ok;
          m_cmds += cmd_ok;
          m_total_cmds += cmd_ok;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  task automatic step();
    @(posedge ui_clk);
    #1;
    if (pop_now) fifo_dout = fifo_dout + 1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!wr_req && n < 50) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, wr_req, 1'b1);
  endtask

  task automatic grant(input string tag);
    step();
    wr_ack = 1'b1;
    fifo_rd_count = '0;
    step();
    wr_ack = 1'b0;
    check({tag, "_req_after_ack"}, wr_req, 1'b0);
  endtask

  // mode 0: clean burst, 1: data-channel stalls, 2: app_rdy toggling
  task automatic do_burst(input string tag, input int mode);
    int b0, c0, d0, n;
    logic [AW-1:0] exp_addr[4];
    logic [AW-1:0] got;
    exp_addr = '{28'd0, 28'd8, 28'd16, 28'd24};
    cmd_log.delete();
    b0 = mon_beats;
    c0 = mon_cmds;
    d0 = mon_dones;
    fifo_rd_count = 10'd4;
    wait_req(tag);
    grant(tag);
    if (mode == 1) begin
      n = 0;
      while (mon_beats - b0 < 1 && n < 20) begin
        step();
        n++;
      end
      app_wdf_rdy = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check({tag, "_stall_beats"}, 64'(mon_beats - b0), 64'd1);
      check({tag, "_stall_cmds"}, 64'(mon_cmds - c0), 64'd1);
      app_wdf_rdy = 1'b1;
      fifo_empty = 1'b1;
      for (int i = 0; i < 2; i++) step();
      check({tag, "_empty_beats"}, 64'(mon_beats - b0), 64'd1);
      fifo_empty = 1'b0;
    end
    n = 0;
    while (mon_dones == d0 && n < 60) begin
      if (mode == 2) app_rdy = ~app_rdy;
      step();
      n++;
    end
    app_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check({tag, "_beats"}, 64'(mon_beats - b0), 64'd4);
    check({tag, "_cmds"}, 64'(mon_cmds - c0), 64'd4);
    check({tag, "_dones"}, 64'(mon_dones - d0), 64'd1);
    check({tag, "_addr_count"}, 64'(cmd_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < cmd_log.size()) ? cmd_log[i] : '1;
      check($sformatf("%s_addr%0d", tag, i), got, exp_addr[i]);
    end
  endtask

  initial begin
    int d0, n, b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_app_en", app_en, 1'b0);
    check("rst_app_addr", app_addr, 28'd0);
    rst = 1'b0;
    fifo_rd_count = 10'd4;
    for (int i = 0; i < 3; i++) step();
    check("no_calib_no_req", wr_req, 1'b0);
    init_calib_complete = 1'b1;

    do_burst("b1", 0);
    do_burst("b2_wrap", 0);
    do_burst("b3_wdf_stall", 1);
    do_burst("b4_rdy_toggle", 2);

    fifo_rd_count = 10'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("count3_no_req", wr_req, 1'b0);
    end
    fifo_rd_count = 10'd4;
    step();
    check("count4_req", wr_req, 1'b1);

    grant("b5_abort");
    b0 = mon_beats;
    d0 = mon_dones;
    n = 0;
    while (mon_beats - b0 < 2 && n < 20) begin
      step();
      n++;
    end
    check("abort_two_beats", 64'(mon_beats - b0), 64'd2);
    rst = 1'b1;
    step();
    check("abort_app_en", app_en, 1'b0);
    check("abort_wren", app_wdf_wren, 1'b0);
    check("abort_rd_en", fifo_rd_en, 1'b0);
    check("abort_addr", app_addr, 28'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("abort_no_done", 64'(mon_dones - d0), 64'd0);
    check("abort_wr_req", wr_req, 1'b0);
    do_burst("b6_after_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
